// File: rtl/camera_pattern_generator.sv
// Image-sensor emulator: parametrised FV/LV timing with selectable pixel patterns.
// Optional CAMERA_PATTERN_TRIGGER_EN adds a trigger port; each trigger emits one frame.
module camera_pattern_generator #(
   parameter int unsigned PIXEL_WIDTH  = 12,
   parameter int unsigned COLS         = 40,
   parameter int unsigned ROWS         = 5,
   parameter int unsigned V_BLANK      = 36,
   parameter int unsigned FV_TO_LV     = 3,
   parameter int unsigned H_BLANK      = 9,
   parameter int unsigned LV_TO_FV_END = 15,
   parameter int unsigned PIXEL_STEP   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [7:0]             frame_count,
   input  logic [1:0]             pattern_sel,
`ifdef CAMERA_PATTERN_TRIGGER_EN
   input  logic                   trigger,
`endif
   output logic                   camera_FV,
   output logic                   camera_LV,
   output logic [PIXEL_WIDTH-1:0] pixel_out,
   output logic                   frame_done,
   output logic                   busy,
   output logic [7:0]             frames_sent
);

   localparam int unsigned CNT_MAX = V_BLANK + FV_TO_LV + COLS + H_BLANK + LV_TO_FV_END;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned RW      = $clog2(ROWS + 1);
   localparam logic [PIXEL_WIDTH-1:0] PIX_CONST = {PIXEL_WIDTH/2{2'b10}};
   localparam logic [PIXEL_WIDTH-1:0] STEP      = PIXEL_WIDTH'(PIXEL_STEP);

   typedef enum logic [2:0] {
      IDLE, VBLANK, FV_LEAD, LINE, HBLANK, FV_TAIL
   } state_t;

   state_t                 state, state_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic [RW-1:0]          row, row_n;
   logic [PIXEL_WIDTH-1:0] acc, acc_n;
   logic [7:0]             fc_r, fc_n;
   logic [1:0]             ps_r, ps_n;
   logic [7:0]             sent_n;
   logic                   done_n, fv_n, lv_n, busy_n;
   logic [PIXEL_WIDTH-1:0] pix_n;
   logic                   start_c;

`ifdef CAMERA_PATTERN_TRIGGER_EN
   assign start_c = enable & trigger;
`else
   assign start_c = enable;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         row         <= '0;
         acc         <= '0;
         fc_r        <= '0;
         ps_r        <= '0;
         camera_FV   <= 1'b0;
         camera_LV   <= 1'b0;
         pixel_out   <= '0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         frames_sent <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         row         <= row_n;
         acc         <= acc_n;
         fc_r        <= fc_n;
         ps_r        <= ps_n;
         camera_FV   <= fv_n;
         camera_LV   <= lv_n;
         pixel_out   <= pix_n;
         frame_done  <= done_n;
         busy        <= busy_n;
         frames_sent <= sent_n;
      end
   end

   // Next-state, counters, and the next value of every registered output.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      row_n   = row;
      acc_n   = acc;
      fc_n    = fc_r;
      ps_n    = ps_r;
      sent_n  = frames_sent;
      done_n  = 1'b0;
      fv_n    = 1'b0;
      lv_n    = 1'b0;
      busy_n  = 1'b0;
      pix_n   = pixel_out;

      case (state)
         IDLE: begin
            if (start_c) begin
               state_n = VBLANK;
               cnt_n   = '0;
               row_n   = '0;
               fc_n    = frame_count;
               ps_n    = pattern_sel;
               sent_n  = '0;
            end
         end
         VBLANK: begin
            if (cnt == CW'(V_BLANK - 1)) begin
               state_n = FV_LEAD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         FV_LEAD: begin
            if (cnt == CW'(FV_TO_LV - 1)) begin
               state_n = LINE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         LINE: begin
            if (cnt == CW'(COLS - 1)) begin
               state_n = HBLANK;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         HBLANK: begin
            if (cnt == CW'(H_BLANK - 1)) begin
               cnt_n   = '0;
               row_n   = row + RW'(1);
               state_n = (row_n < RW'(ROWS)) ? LINE : FV_TAIL;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         FV_TAIL: begin
            if (cnt == CW'(LV_TO_FV_END - 1)) begin
               cnt_n  = '0;
               done_n = 1'b1;
               sent_n = frames_sent + 8'd1;
               // Continuation re-uses the frame_count/pattern_sel captured at start.
               if ((fc_r != 8'd0) && (sent_n == fc_r)) begin
                  state_n = IDLE;
               end else if (start_c) begin
                  state_n = VBLANK;
                  row_n   = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      fv_n   = state_n inside {FV_LEAD, LINE, HBLANK, FV_TAIL};
      lv_n   = (state_n == LINE);
      busy_n = (state_n != IDLE);

      // Pixel generation; the bus holds its value while idle.
      if (state_n != IDLE) begin
         acc_n = acc + STEP;
         case (ps_n)
            2'd0:    pix_n = acc_n;
            2'd1:    pix_n = lv_n ? PIXEL_WIDTH'(cnt_n) : '0;
            2'd2:    pix_n = (lv_n && (row_n[0] ^ cnt_n[0])) ? '1 : '0;
            default: pix_n = lv_n ? PIX_CONST : '0;
         endcase
      end
   end

endmodule

// File: tb/tb_camera_pattern_generator.sv
// Self-checking bench for camera_pattern_generator against a frame-timing reference model.
module tb_camera_pattern_generator;

   localparam int PW     = 12;
   localparam int C      = 40;
   localparam int R      = 5;
   localparam int VB     = 36;
   localparam int FL     = 3;
   localparam int HB     = 9;
   localparam int LT     = 15;
   localparam int STEP   = 16;
   localparam int LINE_P = C + HB;
   localparam int FVH    = FL + R * LINE_P + LT;
   localparam int P      = VB + FVH;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [7:0]    frame_count;
   logic [1:0]    pattern_sel;
`ifdef CAMERA_PATTERN_TRIGGER_EN
   logic          trigger;
`endif
   logic          camera_FV;
   logic          camera_LV;
   logic [PW-1:0] pixel_out;
   logic          frame_done;
   logic          busy;
   logic [7:0]    frames_sent;

   int checks   = 0;
   int failures = 0;
   int model_acc;
   int model_last;

   camera_pattern_generator dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .frame_count (frame_count),
      .pattern_sel (pattern_sel),
`ifdef CAMERA_PATTERN_TRIGGER_EN
      .trigger     (trigger),
`endif
      .camera_FV   (camera_FV),
      .camera_LV   (camera_LV),
      .pixel_out   (pixel_out),
      .frame_done  (frame_done),
      .busy        (busy),
      .frames_sent (frames_sent)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs for cycle t of a run emitting nframes frames (t=0 is the first VBLANK cycle).
   task automatic sample(input int t, input int nframes, input int ps);
      bit fv, lv;
      int row, col, tt, f, w, pix;
      if (t < nframes * P) begin
         f  = t / P;
         tt = t % P;
         fv = (tt >= VB);
         lv = 1'b0;
         row = 0;
         col = 0;
         w  = tt - VB - FL;
         if (w >= 0 && w < R * LINE_P) begin
            row = w / LINE_P;
            col = w % LINE_P;
            lv  = (col < C);
         end
         model_acc = (model_acc + STEP) % (1 << PW);
         case (ps)
            0:       pix = model_acc;
            1:       pix = lv ? col : 0;
            2:       pix = (lv && ((row + col) % 2 == 1)) ? 'hFFF : 0;
            default: pix = lv ? 'hAAA : 0;
         endcase
         check("fv",   32'(camera_FV),   32'(fv));
         check("lv",   32'(camera_LV),   32'(lv));
         check("busy", 32'(busy),        32'd1);
         check("done", 32'(frame_done),  32'(tt == 0 && f > 0));
         check("sent", 32'(frames_sent), 32'(f % 256));
         check("pix",  32'(pixel_out),   32'(pix));
         model_last = pix;
      end else begin
         check("idle_fv",   32'(camera_FV),   32'd0);
         check("idle_lv",   32'(camera_LV),   32'd0);
         check("idle_busy", 32'(busy),        32'd0);
         check("idle_done", 32'(frame_done),  32'(t == nframes * P));
         check("idle_sent", 32'(frames_sent), 32'(nframes % 256));
         check("idle_pix",  32'(pixel_out),   32'(model_last));
      end
   endtask

   task automatic run(input int fc, input int ps, input int nframes, input int drop_t);
      @(negedge clk);
      enable      = 1'b1;
      frame_count = 8'(fc);
      pattern_sel = 2'(ps);
      @(posedge clk);
      for (int t = 0; t < nframes * P + 8; t++) begin
         @(negedge clk);
         sample(t, nframes, ps);
         if (t == drop_t) enable = 1'b0;
      end
   endtask

   initial begin
      int fc, ps, k, drop;
      reset       = 1'b1;
      enable      = 1'b0;
      frame_count = 8'd0;
      pattern_sel = 2'd0;
`ifdef CAMERA_PATTERN_TRIGGER_EN
      trigger     = 1'b1;
`endif
      model_acc   = 0;
      model_last  = 0;
      repeat (2) @(negedge clk);
      check("rst_fv",   32'(camera_FV),   32'd0);
      check("rst_lv",   32'(camera_LV),   32'd0);
      check("rst_pix",  32'(pixel_out),   32'd0);
      check("rst_done", 32'(frame_done),  32'd0);
      check("rst_busy", 32'(busy),        32'd0);
      check("rst_sent", 32'(frames_sent), 32'd0);
      reset = 1'b0;

      run(1, 0, 1, 5);
      run(2, 1, 2, P + 5);
      run(1, 2, 1, 3);
      run(1, 3, 1, 3);
      // continuous mode, enable released during row 2: exactly one full frame
      run(0, 0, 1, VB + FL + 2 * LINE_P + 7);

      // asynchronous reset in the middle of a line
      @(negedge clk);
      enable      = 1'b1;
      frame_count = 8'd1;
      pattern_sel = 2'd1;
      @(posedge clk);
      for (int t = 0; t <= VB + FL + 10; t++) begin
         @(negedge clk);
         sample(t, 1, 1);
      end
      #2 reset = 1'b1;
      enable = 1'b0;
      #1;
      check("arst_fv",   32'(camera_FV),  32'd0);
      check("arst_lv",   32'(camera_LV),  32'd0);
      check("arst_pix",  32'(pixel_out),  32'd0);
      check("arst_busy", 32'(busy),       32'd0);
      check("arst_done", 32'(frame_done), 32'd0);
      model_acc  = 0;
      model_last = 0;
      @(negedge clk);
      reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("post_fv",   32'(camera_FV),   32'd0);
         check("post_done", 32'(frame_done),  32'd0);
         check("post_busy", 32'(busy),        32'd0);
         check("post_sent", 32'(frames_sent), 32'd0);
         check("post_pix",  32'(pixel_out),   32'd0);
      end
      run(1, 0, 1, P - 5);

      // randomized frame counts and patterns
      repeat (4) begin
         fc   = int'($urandom_range(1, 3));
         ps   = int'($urandom_range(0, 3));
         drop = (fc - 1) * P + int'($urandom_range(0, P - 1));
         run(fc, ps, fc, drop);
      end
      repeat (2) begin
         k    = int'($urandom_range(0, 1));
         ps   = int'($urandom_range(0, 3));
         drop = k * P + int'($urandom_range(0, P - 2));
         run(0, ps, k + 1, drop);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
